// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register write arbiter: state encoding,
// parameter limits and a one-hot helper.
package shared_reg_pkg;

    localparam int unsigned MIN_N          = 2;
    localparam int unsigned MAX_N          = 16;
    localparam int unsigned MIN_HOLD       = 1;
    localparam int unsigned MAX_HOLD_LIMIT = 255;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    // Bits at or above n stay clear so the result can be truncated to n bits.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            res[i] = (i == idx) && (i < n);
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upwards with wrap-around.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned cand;
            cand = (32'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared W-bit register; the owner may hold
// the grant across up to MAX_HOLD writes while its lock line is high.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 CLK,
    input  logic                 n_Reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic [W-1:0]         Q,
    output logic                 wr_strobe
);

    localparam int unsigned IW = $clog2(N);

    if (N < MIN_N || N > MAX_N) begin : g_bad_n
        $error("shared_reg_arbiter: N must be in 2..16");
    end
    if (MAX_HOLD < MIN_HOLD || MAX_HOLD > MAX_HOLD_LIMIT) begin : g_bad_hold
        $error("shared_reg_arbiter: MAX_HOLD must be in 1..255");
    end

    state_t         state_q;
    logic [IW-1:0]  ptr_q;
    logic [7:0]     hcnt_q;

    logic [N-1:0]   owner_oh;
    logic [N-1:0]   pick_oh;
    logic [N-1:0]   pick_req;
    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic [IW-1:0]  ptr_next;
    logic [W-1:0]   owner_wdata;
    logic           owner_req;
    logic           owner_lock;
    logic           hold_done;
    logic           release_now;
    logic           q_we;

    always_comb begin
        owner_oh    = N'(onehot(32'(owner), N));
        pick_oh     = N'(onehot(32'(pick_idx), N));
        owner_req   = req[owner];
        owner_lock  = lock[owner];
        owner_wdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (owner == IW'(i)) begin
                owner_wdata = wdata[i*W +: W];
            end
        end
        // While owned, the current owner never wins the re-arbitration.
        pick_req    = (state_q == OWNED) ? (req & ~owner_oh) : req;
        hold_done   = (hcnt_q + 8'd1) == 8'(MAX_HOLD);
        release_now = !owner_req || !owner_lock || hold_done;
        q_we        = (state_q == OWNED) && owner_req;
        ptr_next    = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
    end

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req   (pick_req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge CLK or negedge n_Reset) begin
        if (!n_Reset) begin
            state_q   <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            ptr_q     <= '0;
            hcnt_q    <= '0;
        end else begin
            wr_strobe <= q_we;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt     <= pick_oh;
                        owner   <= pick_idx;
                        busy    <= 1'b1;
                        ptr_q   <= ptr_next;
                        hcnt_q  <= '0;
                        state_q <= OWNED;
                    end
                end
                OWNED: begin
                    if (owner_req) begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                    if (release_now) begin
                        if (pick_found) begin
                            gnt    <= pick_oh;
                            owner  <= pick_idx;
                            ptr_q  <= ptr_next;
                            hcnt_q <= '0;
                        end else begin
                            gnt     <= '0;
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge n_Reset) begin
        if (!n_Reset) begin
            Q <= '0;
        end else if (q_we) begin
            Q <= owner_wdata;
        end
    end

endmodule
